// File: rtl/cpu_pkg.sv
// Shared pipeline-tag types and the forwarding-select rule for the hazard/forwarding unit.
package cpu_pkg;
  localparam int TAG_W = 5;
  localparam logic [TAG_W-1:0] XZR = 5'd31;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic [TAG_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
  } stage_tag_t;

  typedef struct packed {
    stage_tag_t       tag;
    logic [TAG_W-1:0] ra;
    logic [TAG_W-1:0] rb;
    logic             ra_used;
    logic             rb_used;
  } ex_tag_t;

  // Youngest writer wins; XZR reads and unused operands always come from the register file.
  function automatic fwd_sel_t fwd_pick(input logic [TAG_W-1:0] r, input logic used,
                                        input stage_tag_t mem, input stage_tag_t wb);
    fwd_sel_t sel;
    sel = FWD_REG;
    if (used && r != XZR) begin
      if (mem.reg_write && mem.rd == r)     sel = FWD_EXMEM;
      else if (wb.reg_write && wb.rd == r)  sel = FWD_MEMWB;
    end
    return sel;
  endfunction
endpackage

// File: rtl/stage_tag_reg.sv
// One pipeline tag register; a bubble loads the all-zero (inert) tag.
module stage_tag_reg
  import cpu_pkg::*;
#(
  parameter type T = stage_tag_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bubble_i,
  input  T     d_i,
  output T     q_o
);
  T tag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        tag_q <= '0;
    else if (bubble_i) tag_q <= '0;
    else               tag_q <= d_i;
  end

  assign q_o = tag_q;
endmodule

// File: rtl/hazard_fwd_unit.sv
// Load-use stall detection and EX operand forwarding selects from EX/MEM/WB destination tags.
module hazard_fwd_unit
  import cpu_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_ra,
  input  logic [REG_W-1:0] id_rb,
  input  logic             id_ra_used,
  input  logic             id_rb_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_count
);
  ex_tag_t    ex_d, ex_q;
  stage_tag_t mem_q, wb_q;
  logic       ld_hit, ex_bubble;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  assign ex_d.tag.rd        = id_rd;
  assign ex_d.tag.reg_write = id_reg_write;
  assign ex_d.tag.mem_read  = id_mem_read;
  assign ex_d.ra            = id_ra;
  assign ex_d.rb            = id_rb;
  assign ex_d.ra_used       = id_ra_used;
  assign ex_d.rb_used       = id_rb_used;

  assign ld_hit = ex_q.tag.mem_read && (ex_q.tag.rd != XZR) &&
                  ((id_ra_used && id_ra == ex_q.tag.rd) || (id_rb_used && id_rb == ex_q.tag.rd));
  // A flushed decode slot can't stall; either way EX takes a bubble.
  assign stall     = ld_hit && !flush;
  assign ex_bubble = stall || flush;

  stage_tag_reg #(.T(ex_tag_t)) u_ex (
    .clk(clk), .rst_n(reset), .bubble_i(ex_bubble), .d_i(ex_d), .q_o(ex_q)
  );
  stage_tag_reg #(.T(stage_tag_t)) u_mem (
    .clk(clk), .rst_n(reset), .bubble_i(1'b0), .d_i(ex_q.tag), .q_o(mem_q)
  );
  stage_tag_reg #(.T(stage_tag_t)) u_wb (
    .clk(clk), .rst_n(reset), .bubble_i(1'b0), .d_i(mem_q), .q_o(wb_q)
  );

  assign fwd_a_sel = fwd_pick(ex_q.ra, ex_q.ra_used, mem_q, wb_q);
  assign fwd_b_sel = fwd_pick(ex_q.rb, ex_q.rb_used, mem_q, wb_q);

  assign cnt_d = (stall && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign stall_count = cnt_q;
endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Tracks destination-register tags of in-flight instructions through the EX, MEM and WB stages of the 64-bit pipelined CPU.
- Produces per-operand forwarding selects for the ALU-input muxes.
- Produces a load-use stall for the fetch and decode stages.
- Consumes the decode-stage read-register numbers, including the 5-bit second-operand address chosen by the Reg2Loc 5-bit 2:1 mux (Rm vs Rd).

Parameters:
- REG_W, 5, register-number width.
- CNT_W, 16, width of the saturating stall-event counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- id_ra  input  REG_W  decode-stage read register A (Rn).
- id_rb  input  REG_W  decode-stage read register B (output of the Reg2Loc mux).
- id_ra_used  input  1  instruction in decode actually reads A.
- id_rb_used  input  1  instruction in decode actually reads B.
- id_rd  input  REG_W  decode-stage destination register.
- id_reg_write  input  1  instruction in decode writes the register file.
- id_mem_read  input  1  instruction in decode is a load.
- flush  input  1  taken branch; discard the instruction in decode.
- stall  output  1  hold PC and IF/ID; inject bubble into EX.
- fwd_a_sel  output  2  ALU operand-A source for the instruction in EX.
- fwd_b_sel  output  2  ALU operand-B source for the instruction in EX.
- stall_count  output  CNT_W  number of load-use stall cycles, saturating.

Behaviour:
- Internal stage tags EX, MEM and WB; each holds rd, reg_write, mem_read. EX also holds ra, rb, ra_used, rb_used.
- Reset, asynchronous, active-low:
  - all tags cleared (reg_write=0, mem_read=0, used=0, registers=0);
  - stall=0, fwd_a_sel=fwd_b_sel=00, stall_count=0;
  - these values hold while reset=0 and apply immediately on assertion, including mid-operation.
- Each rising edge (reset=1):
  - WB <= MEM and MEM <= EX, unconditionally.
  - EX <= decode fields when stall=0 and flush=0.
  - Otherwise EX <= bubble (reg_write=0, mem_read=0, used=0).
- Load-use stall, combinational from EX tag and decode inputs:
  - stall = ex.mem_read & (ex.rd != XZR) & ((id_ra_used & id_ra==ex.rd) | (id_rb_used & id_rb==ex.rd)) & !flush.
  - Exactly one stall cycle per load-use pair: the next cycle EX holds a bubble, so stall drops.
  - Flush wins over stall: the decode instruction is discarded, stall=0, bubble injected.
- Forwarding, combinational from registered tags only, zero added latency:
  - fwd_a_sel = FWD_EXMEM when mem.reg_write & ex.ra_used & mem.rd==ex.ra & ex.ra!=XZR.
  - else FWD_MEMWB when the same condition holds against wb.
  - else FWD_REG.
  - fwd_b_sel uses the same rule with rb.
  - MEM has priority over WB when both match (youngest value wins).
  - XZR (31) is never forwarded; operand reads of 31 always select FWD_REG.
  - The ex.ra_used / ex.rb_used gating applies to both the MEM and WB matches.
- Register file writes in the first half-cycle, so WB to decode needs no bypass here.
- stall_count increments by 1 on each rising edge where stall=1; it saturates at all-ones and does not wrap.
- Loads to XZR never stall.
- Simultaneous flush and load-use match: no stall, no count increment.

Decomposition:
- Shared package cpu_pkg holds:
  - XZR = 5'd31;
  - fwd_sel_t enum: FWD_REG=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10 (2'b11 unused);
  - stage_tag_t struct {rd, reg_write, mem_read}.
- One natural sub-module: stage_tag_reg, a tag pipeline register with async active-low reset and a bubble input, instantiated for EX, MEM and WB.

Test Plan:
- Reset:
  - Stimulus: reset=0 with arbitrary inputs, release, idle 3 cycles.
  - Required: stall=0, fwd_a_sel=fwd_b_sel=00, stall_count=0 throughout.
- EX/MEM forward:
  - Stimulus: ADD X3 (id_rd=3, reg_write=1), then next cycle SUB reading ra=3, rb=4.
  - Required: when SUB is in EX, fwd_a_sel=01, fwd_b_sel=00.
- MEM/WB forward and priority:
  - Stimulus A: ADD X5, then an independent instruction, then a reader of rb=5.
  - Required A: fwd_b_sel=10.
  - Stimulus B: two consecutive writers of X5, then a reader of X5.
  - Required B: fwd_b_sel=01.
- Load-use:
  - Stimulus: LDUR X7 (mem_read=1), then ADD reading ra=7.
  - Required: stall=1 for exactly one cycle; next cycle EX holds a bubble; then fwd_a_sel=10; stall_count=1.
  - Stimulus: same sequence with rb=7 and id_rb_used=0.
  - Required: no stall.
- XZR and flush:
  - Stimulus: LDUR X31 followed by a reader of X31.
  - Required: no stall, fwd=00.
  - Stimulus: load-use pair with flush=1 in the stall cycle.
  - Required: stall=0, count unchanged, EX bubble.
- Saturation and reset mid-stream:
  - Stimulus: preload stall_count near max (CNT_W=4), force 20 stalls.
  - Required: stall_count holds 15.
  - Stimulus: assert reset between edges.
  - Required: outputs clear immediately.
